fifo_byte_reader: RTL and testbench

FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

---
 rtl/fifo_byte_reader_if.sv | 40 ++++
 rtl/fifo_byte_reader.sv | 104 ++++++++++
 tb/tb_fifo_byte_reader.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_byte_reader_if.sv
// Bus bundle for the FIFO byte reader: the FIFO read side and the byte stream.
//
// Handshake rules:
//   - FIFO side: fifo_rd_en is a one-cycle read request. It is raised only
//     while fifo_empty is low. fifo_data is valid in the cycle after the request.
//   - Stream side: m_valid/m_ready follow strict valid/ready semantics. A byte
//     moves on a rising clk edge where both are high. Once m_valid rises,
//     m_data, m_last and m_valid stay stable until that transfer happens.
//     m_valid never depends on m_ready. m_last marks the 4th byte of a word.
interface fifo_byte_reader_if;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    // The reader side: pulls words from the FIFO and sources the byte stream.
    modport master (
        input  fifo_empty,
        input  fifo_data,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_last
    );

    // The environment side: the FIFO plus the downstream byte sink.
    modport slave (
        output fifo_empty,
        output fifo_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_last
    );
endinterface

// File: rtl/fifo_byte_reader.sv
// FIFO byte reader: pops 32-bit words from a FIFO and emits them as four bytes
// on a valid/ready byte stream. MSB_FIRST selects the byte order.
module fifo_byte_reader #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    fifo_byte_reader_if.master         bus,
    output logic                       busy,
    output logic [7:0]                 word_count,
    output logic [1:0]                 state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAP  = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  idx;
    logic [1:0]  idx_next;
    logic [31:0] hold;
    logic [31:0] hold_next;
    logic [7:0]  count_next;
    logic [1:0]  sel;
    logic        xfer;

    // A byte moves only when presented and accepted. m_ready is ignored otherwise.
    assign xfer = (state == SEND) && bus.m_ready;

    // Byte lane within the holding register that is currently presented.
    assign sel = MSB_FIRST ? (2'd3 - idx) : idx;

    // Next-state logic. fifo_empty is looked at only in IDLE and on the
    // final-byte transfer, so a read is never issued against an empty FIFO.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold;
        count_next = word_count;
        case (state)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = CAP;
            end
            CAP: begin
                hold_next  = bus.fifo_data;
                idx_next   = 2'd0;
                state_next = SEND;
            end
            SEND: begin
                if (xfer) begin
                    if (idx == 2'd3) begin
                        count_next = word_count + 8'd1;
                        state_next = bus.fifo_empty ? IDLE : REQ;
                    end else begin
                        idx_next = idx + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, byte index, holding register and word counter. Reset wins over
    // everything and drops any partially sent word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            hold       <= 32'h0;
            word_count <= 8'h00;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            hold       <= hold_next;
            word_count <= count_next;
        end
    end

    // Outputs decoded from the registered state. Data is forced to zero
    // outside SEND so the stream is quiet when nothing is presented.
    always_comb begin
        bus.fifo_rd_en = (state == REQ);
        bus.m_valid    = (state == SEND);
        bus.m_last     = (state == SEND) && (idx == 2'd3);
        bus.m_data     = 8'h00;
        if (state == SEND) begin
            bus.m_data = hold[{sel, 3'b000} +: 8];
        end
        busy      = (state != IDLE);
        state_dbg = state;
    end

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Self-checking bench for fifo_byte_reader. Two instances (LSB-first and
// MSB-first) run the same stimulus against a queue-based FIFO and byte model.
module tb_fifo_byte_reader;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_byte_reader_if bus0();
    fifo_byte_reader_if bus1();

    logic       busy0, busy1;
    logic [7:0] wc0, wc1;
    logic [1:0] st0, st1;

    fifo_byte_reader #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .word_count(wc0), .state_dbg(st0)
    );
    fifo_byte_reader #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .word_count(wc1), .state_dbg(st1)
    );

    // ---------------- model state ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] fq0[$];
    logic [31:0] fq1[$];
    logic [8:0]  exp_q0[$];
    logic [8:0]  exp_q1[$];
    logic [31:0] pend_w[2];
    logic        pend_v[2];
    logic        stall[2];
    logic [9:0]  held[2];
    int          wc_model[2];
    int          xfer_cnt[2];
    int          rd_cnt[2];
    int          busy_cyc[2];
    int          first_xfer[2];
    int          last_xfer[2];

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        for (int id = 0; id < 2; id++) begin
            xfer_cnt[id]   = 0;
            rd_cnt[id]     = 0;
            busy_cyc[id]   = 0;
            first_xfer[id] = 0;
            last_xfer[id]  = 0;
        end
    endtask

    function automatic bit is_idle();
        return (fq0.size() == 0) && (fq1.size() == 0) && (exp_q0.size() == 0) &&
               (exp_q1.size() == 0) && !busy0 && !busy1 && !pend_v[0] && !pend_v[1];
    endfunction

    // A word leaving the FIFO becomes four expected bytes in stream order.
    task automatic model_pop(input int id);
        logic [31:0] w;
        logic [31:0] lo;
        logic [31:0] hi;
        if ((id == 0 && fq0.size() == 0) || (id == 1 && fq1.size() == 0)) begin
            check("pop_from_empty", 32'd1, 32'd0);
            return;
        end
        w = (id == 0) ? fq0.pop_front() : fq1.pop_front();
        pend_w[id] = w;
        pend_v[id] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lo = w >> (8 * i);
            hi = w >> (8 * (3 - i));
            if (id == 0) exp_q0.push_back({(i == 3), lo[7:0]});
            else         exp_q1.push_back({(i == 3), hi[7:0]});
        end
    endtask

    // Scoreboard and protocol checks for one instance, evaluated at the
    // falling edge with the inputs that the next rising edge will see.
    task automatic mon(input int id, input logic v, input logic l, input logic [7:0] d,
                       input logic rd, input logic empty, input logic bsy,
                       input logic rdy, input logic rs);
        logic [8:0] e;
        if (stall[id] && !rs) begin
            check(id == 0 ? "hold0" : "hold1", 32'({v, l, d}), 32'(held[id]));
        end
        stall[id] = v && !rdy && !rs;
        held[id]  = {v, l, d};
        if (bsy) busy_cyc[id]++;
        if (rd) begin
            rd_cnt[id]++;
            check(id == 0 ? "rd_while_empty0" : "rd_while_empty1", 32'(empty), 32'd0);
        end
        if (v && rdy && !rs) begin
            xfer_cnt[id]++;
            if (xfer_cnt[id] == 1) first_xfer[id] = cyc;
            last_xfer[id] = cyc;
            if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
                check(id == 0 ? "extra_byte0" : "extra_byte1", 32'd1, 32'd0);
            end else begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check(id == 0 ? "data0" : "data1", 32'(d), 32'(e[7:0]));
                check(id == 0 ? "last0" : "last1", 32'(l), 32'(e[8]));
                if (e[8]) wc_model[id] = (wc_model[id] + 1) % 256;
            end
        end
    endtask

    // FIFO model: read data appears the cycle after the request, otherwise junk.
    task automatic fifo_step(input int id, input logic rd);
        logic [31:0] d;
        if (pend_v[id]) begin
            d = pend_w[id];
            pend_v[id] = 1'b0;
        end else begin
            d = $urandom();
        end
        if (rd) model_pop(id);
        if (id == 0) begin
            bus0.fifo_data  = d;
            bus0.fifo_empty = (fq0.size() == 0);
        end else begin
            bus1.fifo_data  = d;
            bus1.fifo_empty = (fq1.size() == 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input logic ready, input logic rs);
        @(negedge clk);
        cyc++;
        mon(0, bus0.m_valid, bus0.m_last, bus0.m_data, bus0.fifo_rd_en, bus0.fifo_empty, busy0, ready, rs);
        mon(1, bus1.m_valid, bus1.m_last, bus1.m_data, bus1.fifo_rd_en, bus1.fifo_empty, busy1, ready, rs);
        fifo_step(0, bus0.fifo_rd_en);
        fifo_step(1, bus1.fifo_rd_en);
        rst          = rs;
        bus0.m_ready = ready;
        bus1.m_ready = ready;
    endtask

    task automatic push_word(input logic [31:0] w);
        fq0.push_back(w);
        fq1.push_back(w);
        bus0.fifo_empty = 1'b0;
        bus1.fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready, input int budget);
        int n = 0;
        while (!is_idle() && n < budget) begin
            tick(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0);
            n++;
        end
        check("idle_timeout", 32'(is_idle()), 32'd1);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus0.m_valid && n < budget) begin
            tick(1'b0, 1'b0);
            n++;
        end
        check("valid_timeout", 32'(bus0.m_valid), 32'd1);
    endtask

    // Reset discards any partial word in flight, so the model forgets it too.
    task automatic reset_pulse(input int n);
        exp_q0.delete();
        exp_q1.delete();
        pend_v[0]   = 1'b0;
        pend_v[1]   = 1'b0;
        wc_model[0] = 0;
        wc_model[1] = 0;
        repeat (n) tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] w;
    logic [31:0] b;
    int          to_push;
    int          n;

    initial begin
        bus0.m_ready = 1'b0;  bus1.m_ready = 1'b0;
        bus0.fifo_data = 32'h0;  bus1.fifo_data = 32'h0;
        bus0.fifo_empty = 1'b1;  bus1.fifo_empty = 1'b1;
        for (int id = 0; id < 2; id++) begin
            pend_v[id] = 1'b0; stall[id] = 1'b0; held[id] = 10'h0; wc_model[id] = 0;
        end
        clear_stats();

        // Reset values.
        repeat (3) tick(1'b0, 1'b1);
        check("rst_rd_en0", 32'(bus0.fifo_rd_en), 32'd0);
        check("rst_valid0", 32'(bus0.m_valid), 32'd0);
        check("rst_last0",  32'(bus0.m_last), 32'd0);
        check("rst_busy0",  32'(busy0), 32'd0);
        check("rst_data0",  32'(bus0.m_data), 32'h00);
        check("rst_wc0",    32'(wc0), 32'h00);
        check("rst_valid1", 32'(bus1.m_valid), 32'd0);
        check("rst_data1",  32'(bus1.m_data), 32'h00);
        check("rst_wc1",    32'(wc1), 32'h00);

        // Reset beats a non-empty FIFO.
        push_word(32'hA1B2C3D4);
        repeat (2) tick(1'b0, 1'b1);
        check("rst_prio_rd0",   32'(bus0.fifo_rd_en), 32'd0);
        check("rst_prio_busy0", 32'(busy0), 32'd0);

        // Single word, sink always ready.
        clear_stats();
        wait_idle(1'b0, 50);
        check("w1_rd_pulses0", 32'(rd_cnt[0]), 32'd1);
        check("w1_rd_pulses1", 32'(rd_cnt[1]), 32'd1);
        check("w1_bytes0", 32'(xfer_cnt[0]), 32'd4);
        check("w1_bytes1", 32'(xfer_cnt[1]), 32'd4);
        check("w1_consec0", 32'(last_xfer[0] - first_xfer[0]), 32'd3);
        check("w1_consec1", 32'(last_xfer[1] - first_xfer[1]), 32'd3);
        check("w1_wc0", 32'(wc0), 32'd1);
        check("w1_wc1", 32'(wc1), 32'd1);

        // Stall for 5 cycles while the second byte is presented.
        clear_stats();
        w = 32'hA1B2C3D4;
        push_word(w);
        wait_valid(20);
        tick(1'b1, 1'b0);
        repeat (5) begin
            tick(1'b0, 1'b0);
            b = w >> 8;
            check("stall_data0",  32'(bus0.m_data), 32'(b[7:0]));
            check("stall_valid0", 32'(bus0.m_valid), 32'd1);
            b = w >> 16;
            check("stall_data1",  32'(bus1.m_data), 32'(b[7:0]));
        end
        wait_idle(1'b0, 50);
        check("stall_bytes0", 32'(xfer_cnt[0]), 32'd4);
        check("stall_bytes1", 32'(xfer_cnt[1]), 32'd4);
        check("stall_wc0", 32'(wc0), 32'(wc_model[0]));

        // Three queued words back-to-back.
        clear_stats();
        push_word(32'h00000001);
        push_word(32'h00000002);
        push_word(32'h00000003);
        wait_idle(1'b0, 100);
        check("b2b_bytes0", 32'(xfer_cnt[0]), 32'd12);
        check("b2b_rd0", 32'(rd_cnt[0]), 32'd3);
        check("b2b_busy_cycles0", 32'(busy_cyc[0]), 32'd18);
        check("b2b_busy_cycles1", 32'(busy_cyc[1]), 32'd18);
        check("b2b_span0", 32'(last_xfer[0] - first_xfer[0]), 32'd15);
        check("b2b_idle_busy0", 32'(busy0), 32'd0);
        check("b2b_wc0", 32'(wc0), 32'(wc_model[0]));
        check("b2b_wc1", 32'(wc1), 32'(wc_model[1]));

        // Reset after the first byte of a word.
        push_word(32'hDEADBEEF);
        wait_valid(20);
        tick(1'b1, 1'b0);
        reset_pulse(1);
        check("midrst_valid0", 32'(bus0.m_valid), 32'd0);
        check("midrst_valid1", 32'(bus1.m_valid), 32'd0);
        check("midrst_wc0", 32'(wc0), 32'd0);
        check("midrst_wc1", 32'(wc1), 32'd0);
        check("midrst_busy0", 32'(busy0), 32'd0);
        clear_stats();
        push_word(32'h5A6B7C8D);
        wait_idle(1'b0, 50);
        check("postrst_bytes0", 32'(xfer_cnt[0]), 32'd4);
        check("postrst_bytes1", 32'(xfer_cnt[1]), 32'd4);
        check("postrst_wc0", 32'(wc0), 32'd1);

        // 257 random words, random FIFO arrivals and random sink back-pressure.
        reset_pulse(2);
        clear_stats();
        to_push = 257;
        n = 0;
        while ((to_push > 0 || !is_idle()) && n < 40000) begin
            if (to_push > 0 && $urandom_range(0, 3) == 0) begin
                push_word($urandom());
                to_push--;
            end
            tick(1'($urandom_range(0, 1)), 1'b0);
            n++;
        end
        check("rand_timeout", 32'(is_idle() && to_push == 0), 32'd1);
        check("rand_bytes0", 32'(xfer_cnt[0]), 32'd1028);
        check("rand_bytes1", 32'(xfer_cnt[1]), 32'd1028);
        check("rand_wc0", 32'(wc0), 32'h01);
        check("rand_wc1", 32'(wc1), 32'h01);
        check("rand_wc_model0", 32'(wc0), 32'(wc_model[0]));

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
